// File: rtl/t04_timeout_counter_bank.sv
// Bank of independent elapsed-time counters with restart strobe, clear, hold,
// optional wrap, and a programmable timeout threshold per channel.
module t04_timeout_counter_bank #(
    parameter int WIDTH    = 23,
    parameter int CHANNELS = 2,
    parameter int WRAP     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable_edge,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS-1:0]       hold,
    input  logic [CHANNELS*WIDTH-1:0] threshold,
    output logic [CHANNELS*WIDTH-1:0] ct,
    output logic [CHANNELS-1:0]       expired,
    output logic [CHANNELS-1:0]       timeout_pulse,
    output logic [CHANNELS-1:0]       sat,
    output logic                      any_expired
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] r_ct;
            logic             r_pulse;
            logic [WIDTH-1:0] w_ct_next;
            logic [WIDTH-1:0] w_thr;
            logic             w_at_max;
            logic             w_pulse_next;

            assign w_thr    = threshold[gi*WIDTH +: WIDTH];
            assign w_at_max = &r_ct;

            always_comb begin
                w_ct_next = r_ct + ONE;
                if (clear[gi]) begin
                    w_ct_next = '0;
                end else if (enable_edge[gi]) begin
                    // A strobe on an idle counter starts it; otherwise it restarts from 0.
                    w_ct_next = (r_ct == '0) ? ONE : '0;
                end else if (hold[gi]) begin
                    w_ct_next = r_ct;
                end else if (w_at_max) begin
                    w_ct_next = (WRAP != 0) ? '0 : r_ct;
                end
            end

            // Pulse only on the transition onto the threshold, so holding there is silent.
            assign w_pulse_next = (w_thr != '0) && (w_ct_next == w_thr) && (r_ct != w_thr);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ct    <= '0;
                    r_pulse <= 1'b0;
                end else begin
                    r_ct    <= w_ct_next;
                    r_pulse <= w_pulse_next;
                end
            end

            assign ct[gi*WIDTH +: WIDTH] = r_ct;
            assign expired[gi]           = (w_thr != '0) && (r_ct >= w_thr);
            assign sat[gi]               = w_at_max;
            assign timeout_pulse[gi]     = r_pulse;
        end
    endgenerate

    assign any_expired = |expired;

endmodule

// File: tb/tb_t04_timeout_counter_bank.sv
// Bench for t04_timeout_counter_bank: a saturating and a wrapping bank (WIDTH=4,
// CHANNELS=3) checked against a cycle-level reference model.
module tb_t04_timeout_counter_bank;
    localparam int W    = 4;
    localparam int N    = 3;
    localparam int MAXV = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N-1:0]   en   [2];
    logic [N-1:0]   clr  [2];
    logic [N-1:0]   hld  [2];
    logic [N*W-1:0] thr  [2];
    logic [N*W-1:0] ct   [2];
    logic [N-1:0]   expd [2];
    logic [N-1:0]   tp   [2];
    logic [N-1:0]   sato [2];
    logic           anyx [2];

    int m_ct [2][N];
    bit m_tp [2][N];
    int n_tests = 0;
    int n_fail  = 0;

    t04_timeout_counter_bank #(.WIDTH(W), .CHANNELS(N), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .enable_edge(en[0]), .clear(clr[0]), .hold(hld[0]),
        .threshold(thr[0]), .ct(ct[0]), .expired(expd[0]), .timeout_pulse(tp[0]),
        .sat(sato[0]), .any_expired(anyx[0]));

    t04_timeout_counter_bank #(.WIDTH(W), .CHANNELS(N), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .enable_edge(en[1]), .clear(clr[1]), .hold(hld[1]),
        .threshold(thr[1]), .ct(ct[1]), .expired(expd[1]), .timeout_pulse(tp[1]),
        .sat(sato[1]), .any_expired(anyx[1]));

    function automatic int thr_of(int k, int c);
        return int'(thr[k][c*W +: W]);
    endfunction

    function automatic int dut_ct(int k, int c);
        return int'(ct[k][c*W +: W]);
    endfunction

    function automatic bit m_expired(int k, int c);
        return (thr_of(k, c) != 0) && (m_ct[k][c] >= thr_of(k, c));
    endfunction

    // Advance one clock and apply the counter rules to the model.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
                int t;
                int nx;
                t = thr_of(k, c);
                if (rst) begin
                    nx = 0;
                    m_tp[k][c] = 1'b0;
                end else begin
                    if (clr[k][c])                nx = 0;
                    else if (en[k][c])            nx = (m_ct[k][c] == 0) ? 1 : 0;
                    else if (hld[k][c])           nx = m_ct[k][c];
                    else if (m_ct[k][c] == MAXV)  nx = (k == 1) ? 0 : MAXV;
                    else                          nx = m_ct[k][c] + 1;
                    m_tp[k][c] = (t != 0) && (nx == t) && (m_ct[k][c] != t);
                end
                m_ct[k][c] = nx;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
                n_tests++;
                if (dut_ct(k, c) !== 0 || tp[k][c] !== 1'b0 || sato[k][c] !== 1'b0 || expd[k][c] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset k%0d c%0d: ct=%0d tp=%b sat=%b exp=%b, want 0 0 0 0",
                             k, c, dut_ct(k, c), tp[k][c], sato[k][c], expd[k][c]);
                end
            end
            n_tests++;
            if (anyx[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_any k%0d: got %b want 0", k, anyx[k]);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_count();
        thr[0] = '0;
        thr[1] = '0;
        rst    = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            int es;
            tick();
            es = (i < MAXV) ? i : MAXV;
            n_tests++;
            if (dut_ct(0, 0) !== es || sato[0][0] !== (es == MAXV)) begin
                n_fail++;
                $display("FAIL count_sat i%0d: ct=%0d sat=%b want ct=%0d sat=%b",
                         i, dut_ct(0, 0), sato[0][0], es, es == MAXV);
            end
            n_tests++;
            if (dut_ct(1, 0) !== (i % 16)) begin
                n_fail++;
                $display("FAIL count_wrap i%0d: ct=%0d want %0d", i, dut_ct(1, 0), i % 16);
            end
        end
        $display("[TB] test_count done");
    endtask

    task automatic test_edge_toggle();
        int seq [5] = '{0, 1, 2, 0, 1};
        clr[0] = 3'b001;
        tick();
        clr[0] = 3'b000;
        for (int i = 0; i < 7; i++) tick();
        n_tests++;
        if (dut_ct(0, 0) !== 7) begin
            n_fail++;
            $display("FAIL edge_pre: ct=%0d want 7", dut_ct(0, 0));
        end
        en[0] = 3'b001;
        tick();
        en[0] = 3'b000;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (dut_ct(0, 0) !== seq[i]) begin
                n_fail++;
                $display("FAIL edge_restart step%0d: ct=%0d want %0d", i, dut_ct(0, 0), seq[i]);
            end
            if (i < 2) tick();
        end
        clr[0] = 3'b001;
        tick();
        clr[0] = 3'b000;
        en[0]  = 3'b001;
        // A held-high strobe must alternate 1,0,1,0 from an idle counter.
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (dut_ct(0, 0) !== ((i % 2 == 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL edge_toggle step%0d: ct=%0d want %0d", i, dut_ct(0, 0), (i % 2 == 0) ? 1 : 0);
            end
        end
        en[0] = 3'b000;
        $display("[TB] test_edge_toggle done");
    endtask

    task automatic test_timeout();
        int pulses = 0;
        thr[0] = {4'd0, 4'd5, 4'd0};
        clr[0] = 3'b110;
        tick();
        clr[0] = 3'b000;
        for (int i = 1; i <= 20; i++) begin
            int c;
            tick();
            c = (i < MAXV) ? i : MAXV;
            if (tp[0][1] === 1'b1) pulses++;
            n_tests++;
            if (dut_ct(0, 1) !== c || tp[0][1] !== (c == 5) || expd[0][1] !== (c >= 5)) begin
                n_fail++;
                $display("FAIL timeout i%0d: ct=%0d tp=%b exp=%b want ct=%0d tp=%b exp=%b",
                         i, dut_ct(0, 1), tp[0][1], expd[0][1], c, c == 5, c >= 5);
            end
            n_tests++;
            if (tp[0][2] !== 1'b0 || expd[0][2] !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_disabled i%0d: tp=%b exp=%b want 0 0", i, tp[0][2], expd[0][2]);
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL timeout_pulse_count: got %0d want 1", pulses);
        end
        $display("[TB] test_timeout done");
    endtask

    task automatic test_wrap();
        int pulses = 0;
        thr[1] = {4'd0, 4'd0, 4'd3};
        clr[1] = 3'b001;
        tick();
        clr[1] = 3'b000;
        for (int i = 1; i <= 40; i++) begin
            int e;
            tick();
            e = i % 16;
            if (tp[1][0] === 1'b1) pulses++;
            n_tests++;
            if (dut_ct(1, 0) !== e || tp[1][0] !== (e == 3) || expd[1][0] !== (e >= 3)) begin
                n_fail++;
                $display("FAIL wrap i%0d: ct=%0d tp=%b exp=%b want ct=%0d tp=%b exp=%b",
                         i, dut_ct(1, 0), tp[1][0], expd[1][0], e, e == 3, e >= 3);
            end
        end
        n_tests++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL wrap_pulse_count: got %0d want 3", pulses);
        end
        $display("[TB] test_wrap done");
    endtask

    task automatic test_priority_hold();
        int pulses = 0;
        thr[0][3:0] = 4'd5;
        clr[0][0] = 1'b1;
        en[0][0]  = 1'b1;
        tick();
        clr[0][0] = 1'b0;
        en[0][0]  = 1'b0;
        n_tests++;
        if (dut_ct(0, 0) !== 0) begin
            n_fail++;
            $display("FAIL clear_beats_edge: ct=%0d want 0", dut_ct(0, 0));
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (tp[0][0] === 1'b1) pulses++;
        end
        hld[0][0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (tp[0][0] === 1'b1) pulses++;
            n_tests++;
            if (dut_ct(0, 0) !== 5) begin
                n_fail++;
                $display("FAIL hold_at_thr step%0d: ct=%0d want 5", i, dut_ct(0, 0));
            end
        end
        hld[0][0] = 1'b0;
        tick();
        n_tests++;
        if (dut_ct(0, 0) !== 6 || pulses != 1) begin
            n_fail++;
            $display("FAIL hold_release: ct=%0d pulses=%0d want ct=6 pulses=1", dut_ct(0, 0), pulses);
        end
        hld[0][0] = 1'b1;
        en[0][0]  = 1'b1;
        tick();
        hld[0][0] = 1'b0;
        en[0][0]  = 1'b0;
        n_tests++;
        if (dut_ct(0, 0) !== 0) begin
            n_fail++;
            $display("FAIL edge_beats_hold: ct=%0d want 0", dut_ct(0, 0));
        end
        for (int i = 0; i < 3; i++) tick();
        thr[0][3:0] = 4'd2;
        #1;
        n_tests++;
        if (expd[0][0] !== 1'b1 || anyx[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL lower_thr_expired: exp=%b any=%b want 1 1", expd[0][0], anyx[0]);
        end
        tick();
        n_tests++;
        if (tp[0][0] !== 1'b0 || dut_ct(0, 0) !== 4) begin
            n_fail++;
            $display("FAIL lower_thr_no_pulse: tp=%b ct=%0d want 0 4", tp[0][0], dut_ct(0, 0));
        end
        thr[1][7:4] = 4'd0;
        clr[1][1] = 1'b1;
        tick();
        clr[1][1] = 1'b0;
        for (int i = 0; i < MAXV; i++) tick();
        hld[1][1] = 1'b1;
        tick();
        tick();
        hld[1][1] = 1'b0;
        n_tests++;
        if (dut_ct(1, 1) !== MAXV || sato[1][1] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_at_max_wrap: ct=%0d sat=%b want 15 1", dut_ct(1, 1), sato[1][1]);
        end
        tick();
        n_tests++;
        if (dut_ct(1, 1) !== 0) begin
            n_fail++;
            $display("FAIL wrap_after_hold: ct=%0d want 0", dut_ct(1, 1));
        end
        $display("[TB] test_priority_hold done");
    endtask

    task automatic test_reset_midrun();
        thr[0] = {4'd7, 4'd7, 4'd7};
        thr[1] = {4'd7, 4'd7, 4'd7};
        for (int k = 0; k < 2; k++) begin
            en[k]  = '0;
            clr[k] = '0;
            hld[k] = '0;
        end
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        en[0] = 3'b111;
        tick();
        rst   = 1'b0;
        en[0] = 3'b000;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
                n_tests++;
                if (dut_ct(k, c) !== 0 || tp[k][c] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_midrun k%0d c%0d: ct=%0d tp=%b want 0 0", k, c, dut_ct(k, c), tp[k][c]);
                end
            end
        end
        $display("[TB] test_reset_midrun done");
    endtask

    task automatic test_random();
        int errs = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            rst = ($urandom_range(99) == 0);
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < N; c++) begin
                    en[k][c]  = ($urandom_range(9) == 0);
                    clr[k][c] = ($urandom_range(24) == 0);
                    hld[k][c] = ($urandom_range(3) == 0);
                    if ($urandom_range(19) == 0) thr[k][c*W +: W] = 4'($urandom_range(15));
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                bit any_m = 1'b0;
                for (int c = 0; c < N; c++) begin
                    any_m |= m_expired(k, c);
                    n_tests++;
                    if (dut_ct(k, c) !== m_ct[k][c] || tp[k][c] !== m_tp[k][c] ||
                        expd[k][c] !== m_expired(k, c) || sato[k][c] !== (m_ct[k][c] == MAXV)) begin
                        n_fail++;
                        errs++;
                        if (errs < 20)
                            $display("FAIL random cyc%0d k%0d c%0d: ct=%0d tp=%b exp=%b sat=%b want ct=%0d tp=%b exp=%b sat=%b",
                                     cyc, k, c, dut_ct(k, c), tp[k][c], expd[k][c], sato[k][c],
                                     m_ct[k][c], m_tp[k][c], m_expired(k, c), m_ct[k][c] == MAXV);
                    end
                end
                n_tests++;
                if (anyx[k] !== any_m) begin
                    n_fail++;
                    errs++;
                    if (errs < 20) $display("FAIL random_any cyc%0d k%0d: got %b want %b", cyc, k, anyx[k], any_m);
                end
            end
        end
        rst = 1'b0;
        $display("[TB] test_random done");
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en[k]  = '0;
            clr[k] = '0;
            hld[k] = '0;
            thr[k] = {4'd5, 4'd5, 4'd5};
            for (int c = 0; c < N; c++) begin
                m_ct[k][c] = 0;
                m_tp[k][c] = 1'b0;
            end
        end
        test_reset();
        test_count();
        test_edge_toggle();
        test_timeout();
        test_wrap();
        test_priority_hold();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
